// File: rtl/period_to_freq_pkg.sv
// Shared constants for the period-to-frequency converter: FSM encodings
// and the default datapath width.
package period_to_freq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/period_to_freq_seq_divider.sv
// Restoring divider, one quotient bit per clock. A start pulse loads the
// operands; done is high during the cycle whose edge completes the last step.
import period_to_freq_pkg::*;

module period_to_freq_seq_divider #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic             active_q, active_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   trial;

    always_comb begin
        active_d  = active_q;
        count_d   = count_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        // The quotient register doubles as the dividend shift register.
        trial     = {rem_q, quot_q[WIDTH-1]};
        if (start) begin
            active_d  = 1'b1;
            count_d   = '0;
            quot_d    = dividend;
            rem_d     = '0;
            divisor_d = divisor;
        end else if (active_q) begin
            if (trial >= {1'b0, divisor_q}) begin
                rem_d  = trial[WIDTH-1:0] - divisor_q;
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = trial[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            count_d = count_q + 1'b1;
            if (count_q == LAST_STEP) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q  <= 1'b0;
            count_q   <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else begin
            active_q  <= active_d;
            count_q   <= count_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
        end
    end

    assign done      = active_q && (count_q == LAST_STEP);
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/period_to_freq.sv
// Converts the detector's average period (clk cycles) into Hz by dividing
// CLK_HZ by it whenever the level-held period word changes.
import period_to_freq_pkg::*;

module period_to_freq #(
    parameter int               WIDTH  = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CLK_HZ = WIDTH'(100_000_000)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] freq,
    output logic             freq_valid,
    output logic             busy
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] last_period_q, last_period_d;
    logic [WIDTH-1:0] freq_q, freq_d;
    logic             freq_valid_q, freq_valid_d;
    logic             busy_q, busy_d;

    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] unused_remainder;

    period_to_freq_seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (CLK_HZ),
        .divisor   (period),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (unused_remainder)
    );

    always_comb begin
        state_d       = state_q;
        last_period_d = last_period_q;
        freq_d        = freq_q;
        freq_valid_d  = 1'b0;
        busy_d        = busy_q;
        div_start     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Changes seen while busy stay pending because last_period
                // still holds the old value until we return here.
                if ((period != last_period_q) && (period != '0)) begin
                    div_start     = 1'b1;
                    last_period_d = period;
                    busy_d        = 1'b1;
                    state_d       = ST_DIV;
                end else if ((period == '0) && (last_period_q != '0)) begin
                    freq_d        = '0;
                    freq_valid_d  = 1'b1;
                    last_period_d = '0;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                freq_d       = div_quotient;
                freq_valid_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_period_q <= '0;
            freq_q        <= '0;
            freq_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_period_q <= last_period_d;
            freq_q        <= freq_d;
            freq_valid_q  <= freq_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_period_to_freq.sv
// Bench for period_to_freq: directed vector table, multi-cycle corner
// sequences and random periods checked against an arithmetic model.
module tb_period_to_freq;

    localparam int          W      = 32;
    localparam logic [31:0] CLK_HZ = 32'd100_000_000;
    localparam int          LAT    = W + 2;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  period;
    logic [W-1:0]  freq;
    logic          freq_valid;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    logic [W-1:0] cur_period = '0;

    period_to_freq #(.WIDTH(W), .CLK_HZ(CLK_HZ)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .period     (period),
        .freq       (freq),
        .freq_valid (freq_valid),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (freq_valid === 1'b1) vcount++;

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] exp_f;
        int           exp_lat;
        bit           exp_busy;
    } vec_t;

    function automatic logic [W-1:0] ref_freq(input logic [W-1:0] p);
        if (p == 0) return '0;
        return CLK_HZ / p;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_period(input logic [W-1:0] p);
        @(negedge clk);
        period = p;
        cur_period = p;
    endtask

    // Waits for the valid pulse, checking latency, value, busy profile and pulse width.
    task automatic wait_result(input string name, input logic [W-1:0] exp_f,
                               input int exp_lat, input bit exp_busy);
        int  lat = 0;
        int  busy_bad = 0;
        bit  seen = 0;
        for (int e = 1; e <= 120 && !seen; e++) begin
            @(posedge clk);
            #1;
            if (busy !== (exp_busy && (e < exp_lat))) busy_bad++;
            if (freq_valid === 1'b1) begin
                seen = 1;
                lat = e;
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_freq"}, freq, exp_f);
        check({name, "_busy"}, busy_bad, 0);
        @(posedge clk);
        #1;
        check({name, "_pulse_width"}, {31'd0, freq_valid}, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int v0;
        int hits;
        int hit_lat[2];
        logic [W-1:0] hit_f[2];
        logic [W-1:0] p;

        vecs[0] = '{32'd100_000,     32'd1000,        LAT, 1'b1};
        vecs[1] = '{32'd3,           32'd33_333_333,  LAT, 1'b1};
        vecs[2] = '{32'd1,           32'd100_000_000, LAT, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF,   32'd0,           LAT, 1'b1};
        vecs[4] = '{32'd7,           32'd14_285_714,  LAT, 1'b1};
        vecs[5] = '{32'd0,           32'd0,           1,   1'b0};
        vecs[6] = '{32'd250,         32'd400_000,     LAT, 1'b1};

        reset_n = 1'b0;
        period  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_freq", freq, 0);
        check("reset_valid", {31'd0, freq_valid}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Post-reset zero period must not trigger anything.
        repeat (40) @(posedge clk);
        #1;
        check("idle_zero_pulses", vcount, 0);
        check("idle_zero_busy", {31'd0, busy}, 0);

        foreach (vecs[i]) begin
            drive_period(vecs[i].p);
            wait_result($sformatf("vec%0d", i), vecs[i].exp_f, vecs[i].exp_lat, vecs[i].exp_busy);
        end

        // Period change at DIV edge 10 is converted after the first result.
        v0 = vcount;
        hits = 0;
        drive_period(32'd100_000);
        repeat (11) @(posedge clk);
        drive_period(32'd250);
        for (int e = 12; e <= 150; e++) begin
            @(posedge clk);
            #1;
            if (freq_valid === 1'b1) begin
                if (hits < 2) begin
                    hit_lat[hits] = e;
                    hit_f[hits] = freq;
                end
                hits++;
            end
        end
        check("mid_change_pulses", hits, 2);
        if (hits >= 2) begin
            check("mid_change_first_lat", hit_lat[0], LAT);
            check("mid_change_first_freq", hit_f[0], 32'd1000);
            check("mid_change_second_lat", hit_lat[1], 2 * LAT);
            check("mid_change_second_freq", hit_f[1], 32'd400_000);
        end
        check("mid_change_vcount", vcount - v0, 2);

        // Held period produces no further pulses.
        drive_period(32'd100_000);
        wait_result("hold_conv", 32'd1000, LAT, 1'b1);
        v0 = vcount;
        repeat (200) @(posedge clk);
        #1;
        check("hold_no_pulses", vcount - v0, 0);
        check("hold_freq", freq, 32'd1000);

        for (int i = 0; i < 20; i++) begin
            if (cur_period != 0 && $urandom_range(0, 7) == 0) begin
                p = '0;
            end else begin
                case ($urandom_range(0, 2))
                    0:       p = $urandom_range(1, 1000);
                    1:       p = $urandom_range(1000, 2_000_000);
                    default: p = $urandom;
                endcase
                if (p == cur_period) p = p ^ 32'd1;
                if (p == 0) p = 32'd2;
            end
            drive_period(p);
            if (p == 0)
                wait_result($sformatf("rand%0d_zero", i), '0, 1, 1'b0);
            else
                wait_result($sformatf("rand%0d_p%0d", i, p), ref_freq(p), LAT, 1'b1);
        end

        // Reset pulse at DIV edge 15 aborts the conversion.
        drive_period(32'd5);
        wait_result("pre_reset", 32'd20_000_000, LAT, 1'b1);
        drive_period(32'd123_457);
        repeat (16) @(posedge clk);
        @(negedge clk);
        v0 = vcount;
        reset_n = 1'b0;
        #1;
        check("abort_freq", freq, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_valid", {31'd0, freq_valid}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_no_pulse", vcount - v0, 0);
        wait_result("post_reset", ref_freq(32'd123_457), LAT, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
